paddle_display: RTL



---
 rtl/paddle_display.sv | 102 ++++++++++
 1 files changed

// File: rtl/paddle_display.sv
// paddle_display: erases the previous paddle rectangle, then draws the new one, one pixel per clock
module paddle_display #(
    parameter int PADDLE_W = 16,
    parameter int PADDLE_H = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       reset_counts,
    input  logic       start,
    input  logic [7:0] paddle_x,
    input  logic [6:0] paddle_y,
    input  logic [2:0] colour_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    localparam int N  = PADDLE_W * PADDLE_H;
    localparam int CB = $clog2(N);
    localparam int XB = $clog2(PADDLE_W);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t         state, nxt_state;
    logic [CB-1:0]  cnt, nxt_cnt;
    logic [7:0]     old_x, new_x, src_x, base_x;
    logic [6:0]     old_y, new_y, src_y, base_y;
    logic [2:0]     new_col, src_col, pix_col;
    logic           have_old, last, draw;
    logic [8:0]     sum_x;
    logic [7:0]     sum_y;

    // Outputs are registered, so the pixel for the next state/count is computed here.
    always_comb begin
        last      = cnt == CB'(N - 1);
        src_x     = state == IDLE ? paddle_x : new_x;
        src_y     = state == IDLE ? paddle_y : new_y;
        src_col   = state == IDLE ? colour_in : new_col;
        nxt_state = state;
        nxt_cnt   = cnt + 1'b1;
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (start)
                    nxt_state = !have_old ? DRAW :
                                ({paddle_x, paddle_y} != {old_x, old_y}) ? ERASE : DONE;
            end
            ERASE:   nxt_state = last ? DRAW : ERASE;
            DRAW:    nxt_state = last ? DONE : DRAW;
            default: nxt_state = IDLE;
        endcase
        draw    = nxt_state == ERASE || nxt_state == DRAW;
        base_x  = nxt_state == ERASE ? old_x : src_x;
        base_y  = nxt_state == ERASE ? old_y : src_y;
        pix_col = nxt_state == ERASE ? 3'd0 : src_col;
        sum_x   = {1'b0, base_x} + 9'(nxt_cnt[XB-1:0]);
        sum_y   = {1'b0, base_y} + 8'(nxt_cnt >> XB);
    end

    always_ff @(posedge clock) begin
        if (reset_counts) begin
            state      <= IDLE;
            cnt        <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            old_x      <= '0;
            old_y      <= '0;
            have_old   <= 1'b0;
            new_x      <= '0;
            new_y      <= '0;
            new_col    <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (state == IDLE && start) begin
                new_x   <= paddle_x;
                new_y   <= paddle_y;
                new_col <= colour_in;
            end
            if (state == DONE) begin
                old_x    <= new_x;
                old_y    <= new_y;
                have_old <= 1'b1;
            end
            if (draw) begin
                vga_x      <= sum_x[7:0];
                vga_y      <= sum_y[6:0];
                vga_colour <= pix_col;
            end
            plot <= draw && sum_x < 9'(SCREEN_W) && sum_y < 8'(SCREEN_H);
            busy <= nxt_state != IDLE;
            done <= nxt_state == DONE;
        end
    end
endmodule
